mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 27-bit word mux.
- Four requesters share one downstream consumer; the block chooses a requester and drives the mux select.
- It captures the mux output into a registered output stage and presents it to the consumer with a valid/ready handshake.
- It acknowledges the winning requester and counts completed transfers.

Parameters:
DATA_W, 27, width of mux data path (mux_in, out_data)
CNT_W, 16, width of transfer counter

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  4  request per channel; bit i = channel i (mux input i+1)
mux_in  input  DATA_W  output of the shared 4:1 mux, driven by sel
sel  output  2  mux select (00=in1, 01=in2, 10=in3, 11=in4)
ack  output  4  one-hot, one-cycle pulse: channel's word captured
out_data  output  DATA_W  registered word to consumer
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when out_valid && out_ready
busy  output  1  high in any state other than IDLE
xfer_count  output  CNT_W  completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, any time) forces all of the following:
  - state=IDLE, sel=2'b00, ack=0, out_data=0, out_valid=0, xfer_count=0, priority pointer ptr=0.
  - Any in-flight word is dropped with no ack.
  - Deassertion is used synchronously; the first active edge follows it.
- State machine, 3 states, all outputs registered:
  - IDLE:
    - If req==0, stay in IDLE.
    - Otherwise sel<=winner and go to LOAD.
  - LOAD (sel stable for the whole cycle, so the mux output is settled):
    - out_data<=mux_in, out_valid<=1.
    - ack[sel]<=1 for exactly one cycle, visible in the first HOLD cycle.
    - ptr<=sel+1 (mod 4), then go to HOLD.
    - Capture is unconditional, even if req[sel] dropped this cycle.
  - HOLD:
    - out_valid=1; out_data and sel held stable.
    - While out_ready=0, stay in HOLD.
    - On out_valid&&out_ready:
      - xfer_count<=xfer_count+1.
      - If req!=0 (using the new ptr): sel<=winner, out_valid<=0, go to LOAD.
      - Otherwise out_valid<=0, go to IDLE.
- Winner selection is combinational from req and ptr:
  - Scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first channel with req set wins.
  - The decision is made on the entry edge to LOAD and is not revised.
- Latency:
  - Request in IDLE → out_valid: 2 cycles.
  - Sustained throughput: one word per 2 cycles when out_ready is held high.
- Fairness:
  - A requester that holds req is granted within 4 grants.
  - The just-served channel drops to lowest priority.
- Requester contract: hold req and the mux data stable until ack. Deassert req the cycle ack is seen, or keep it asserted to re-request.
- busy = (state != IDLE).
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- ack bits are never set outside the one cycle after LOAD; at most one bit is set.

Test Plan:
- Reset, then req=4'b0001, mux_in=27'h0000ABC, out_ready=1 → sel=00 one cycle later; out_valid=1 and out_data=27'h0000ABC two cycles later; ack=4'b0001 for one cycle; xfer_count=1; returns to IDLE.
- req=4'b1111 held, out_ready=1, ptr=0 → grant order is channel 0,1,2,3,0; sel sequence 00,01,10,11,00; one ack per 2 cycles.
- req=4'b0101 with ptr=1 (after serving channel 0) → channel 2 granted before channel 0; next grant goes to channel 0.
- out_ready=0 for 5 cycles after out_valid rises → out_valid, out_data and sel stay stable; xfer_count does not change; transfer completes the cycle out_ready rises.
- Assert rst_n=0 asynchronously mid-HOLD (out_valid=1) → all outputs return to reset values immediately, without waiting for a clock edge; no ack; ptr=0; after release, req=4'b1000 gets sel=11.
- Preload xfer_count to 2^16-1 via 65535 transfers (or a force), then complete one more handshake → xfer_count=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 word mux: grants a requester,
// captures the mux output into a registered stage and hands it off via valid/ready.
module mux4_rr_arbiter #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] mux_in,
  output logic [1:0]        sel,
  output logic [3:0]        ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    xfer_count_q, xfer_count_d;

  logic [1:0]          winner;
  logic                winner_vld;
  logic [1:0]          scan_ch;
  logic                handshake;

  // First requesting channel at or after ptr, wrapping modulo 4.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    scan_ch    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_ch = ptr_q + 2'(i);
      if (!winner_vld && req[scan_ch]) begin
        winner     = scan_ch;
        winner_vld = 1'b1;
      end
    end
  end

  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    xfer_count_d = xfer_count_q;

    unique case (state_q)
      IDLE: begin
        if (winner_vld) begin
          sel_d   = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = mux_in;
        out_valid_d = 1'b1;
        ack_d       = 4'b0001 << sel_q;
        ptr_d       = sel_q + 2'd1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          xfer_count_d = xfer_count_q + CNT_W'(1);
          out_valid_d  = 1'b0;
          // ptr_q was already advanced in LOAD, so the just-served channel is last.
          if (winner_vld) begin
            sel_d   = winner;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ptr_q        <= '0;
      ack_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign sel        = sel_q;
  assign ack        = ack_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_count_q;

endmodule
